// File: rtl/fwrisc_mul_seq_if.sv
// Request/response and multiplier-side bundle for fwrisc_mul_seq.
// slave: the sequencer itself; master: the execute stage plus the fast multiplier.
interface fwrisc_mul_seq_if;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_op;
  logic        in_valid;
  logic        in_ready;
  logic        kill;
  logic [31:0] out;
  logic        out_valid;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [3:0]  mul_op;
  logic        mul_valid;
  logic [31:0] mul_out;
  logic        mul_out_valid;

  modport slave (
    input  in_a, in_b, in_op, in_valid, kill, mul_out, mul_out_valid,
    output in_ready, out, out_valid, mul_a, mul_b, mul_op, mul_valid
  );

  modport master (
    output in_a, in_b, in_op, in_valid, kill, mul_out, mul_out_valid,
    input  in_ready, out, out_valid, mul_a, mul_b, mul_op, mul_valid
  );
endinterface

// File: rtl/fwrisc_mul_seq.sv
// Multiply sequencer: reduces MUL/MULH/MULHSU/MULHU to unsigned issues on fwrisc_mul_fast.
// Optional FWRISC_MUL_SEQ_ZERO_BYPASS_EN: zero operand completes directly with result 0.
module fwrisc_mul_seq (
  input  logic            clock,
  input  logic            reset,
  fwrisc_mul_seq_if.slave bus
);

  // Unsigned multiplier opcodes, matching fwrisc_mul_div_shift_op encodings
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_MULH = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE_LO = 3'd1,
    S_WAIT_LO  = 3'd2,
    S_ISSUE_HI = 3'd3,
    S_WAIT_HI  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  function automatic logic [31:0] f_abs(input logic [31:0] x);
    f_abs = x[31] ? (~x + 32'd1) : x;
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_mul_a;
  logic [31:0] r_mul_b;
  logic [3:0]  r_mul_op;
  logic        r_neg;
  logic        r_lo_zero;
  logic [31:0] r_out;

  logic        w_neg;
  logic [31:0] w_ma;
  logic [31:0] w_mb;
  logic        w_bypass;
  logic        w_accept;
  logic        w_capture;
  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_mul_valid;

`ifdef FWRISC_MUL_SEQ_ZERO_BYPASS_EN
  assign w_bypass = (bus.in_a == 32'd0) || (bus.in_b == 32'd0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_accept  = bus.in_valid && !bus.kill && (r_state == S_IDLE);
  assign w_capture = ((r_state == S_WAIT_LO) || (r_state == S_WAIT_HI)) && (w_next == S_DONE);

  // Product sign and unsigned operand conditioning of the incoming request
  always_comb begin
    w_neg = 1'b0;
    w_ma  = bus.in_a;
    w_mb  = bus.in_b;
    case (bus.in_op)
      2'b01: begin
        w_neg = bus.in_a[31] ^ bus.in_b[31];
        w_ma  = f_abs(bus.in_a);
        w_mb  = f_abs(bus.in_b);
      end
      2'b10: begin
        w_neg = bus.in_a[31];
        w_ma  = f_abs(bus.in_a);
      end
      default: begin
        w_neg = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; kill dominates every state
  always_comb begin
    w_next = r_state;
    if (bus.kill) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!bus.in_valid) begin
            w_next = S_IDLE;
          end else if (w_bypass) begin
            w_next = S_DONE;
          end else if ((bus.in_op == 2'b00) || w_neg) begin
            // Negative high products need the low word for the carry-in
            w_next = S_ISSUE_LO;
          end else begin
            w_next = S_ISSUE_HI;
          end
        end
        S_ISSUE_LO: w_next = S_WAIT_LO;
        S_WAIT_LO: begin
          if (!bus.mul_out_valid) begin
            w_next = S_WAIT_LO;
          end else if (r_neg) begin
            w_next = S_ISSUE_HI;
          end else begin
            w_next = S_DONE;
          end
        end
        S_ISSUE_HI: w_next = S_WAIT_HI;
        S_WAIT_HI: begin
          if (bus.mul_out_valid) begin
            w_next = S_DONE;
          end else begin
            w_next = S_WAIT_HI;
          end
        end
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from the state register
  always_comb begin
    w_in_ready  = (r_state == S_IDLE);
    w_mul_valid = (r_state == S_ISSUE_LO) || (r_state == S_ISSUE_HI);
    w_out_valid = (r_state == S_DONE) && !bus.kill;
  end

  // Operand, opcode, low-word-zero flag and result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mul_a   <= 32'd0;
      r_mul_b   <= 32'd0;
      r_mul_op  <= OP_MUL;
      r_neg     <= 1'b0;
      r_lo_zero <= 1'b0;
      r_out     <= 32'd0;
    end else begin
      if (w_accept) begin
        r_mul_a <= w_ma;
        r_mul_b <= w_mb;
        r_neg   <= w_neg;
      end
      if (w_next == S_ISSUE_LO) begin
        r_mul_op <= OP_MUL;
      end else if (w_next == S_ISSUE_HI) begin
        r_mul_op <= OP_MULH;
      end
      if ((r_state == S_WAIT_LO) && bus.mul_out_valid && !bus.kill) begin
        r_lo_zero <= (bus.mul_out == 32'd0);
      end
      // High word of the 64-bit negation: ~hi plus carry out of ~lo + 1
      if (w_capture) begin
        r_out <= r_neg ? (~bus.mul_out + {31'd0, r_lo_zero}) : bus.mul_out;
      end else if (w_accept && w_bypass) begin
        r_out <= 32'd0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out       = r_out;
  assign bus.mul_valid = w_mul_valid;
  assign bus.mul_a     = r_mul_a;
  assign bus.mul_b     = r_mul_b;
  assign bus.mul_op    = r_mul_op;

endmodule

// File: tb/tb_fwrisc_mul_seq.sv
// Directed bench for fwrisc_mul_seq with a behavioural fast multiplier of programmable latency.
module tb_fwrisc_mul_seq;

  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_MULH = 4'd4;

  logic clock;
  logic reset;
  fwrisc_mul_seq_if bus ();

  fwrisc_mul_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  // Multiplier model: result appears lat cycles after the issue edge
  int          lat = 1;
  logic        pv [4];
  logic [31:0] pd [4];
  logic [63:0] m_prod;
  logic [31:0] m_res;
  assign m_prod = {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
  assign m_res  = (bus.mul_op == OP_MULH) ? m_prod[63:32] : m_prod[31:0];
  assign bus.mul_out_valid = pv[0];
  assign bus.mul_out       = pd[0];

  always @(posedge clock) begin
    if (!reset) begin
      pv[0] <= 1'b0; pv[1] <= 1'b0; pv[2] <= 1'b0; pv[3] <= 1'b0;
      pd[0] <= 32'd0; pd[1] <= 32'd0; pd[2] <= 32'd0; pd[3] <= 32'd0;
    end else begin
      pv[0] <= pv[1]; pv[1] <= pv[2]; pv[2] <= pv[3]; pv[3] <= 1'b0;
      pd[0] <= pd[1]; pd[1] <= pd[2]; pd[2] <= pd[3]; pd[3] <= 32'd0;
      if (bus.mul_valid) begin
        pv[lat-1] <= 1'b1;
        pd[lat-1] <= m_res;
      end
    end
  end

  // Issue log
  int          iss_n = 0;
  logic [3:0]  iss_op [256];
  logic [31:0] iss_a  [256];
  logic [31:0] iss_b  [256];

  always @(posedge clock) begin
    if (reset && bus.mul_valid) begin
      iss_op[iss_n[7:0]] <= bus.mul_op;
      iss_a[iss_n[7:0]]  <= bus.mul_a;
      iss_b[iss_n[7:0]]  <= bus.mul_b;
      iss_n <= iss_n + 1;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] exp_out, input int exp_lat,
                         input int exp_iss, input logic [31:0] exp_ma, input logic [31:0] exp_mb);
    int k;
    int n0;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      cyc();
      k++;
    end
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = op;
    bus.in_valid = 1'b1;
    n0 = iss_n;
    cyc();
    bus.in_valid = 1'b0;
    k = 1;
    while (!bus.out_valid && k < 40) begin
      cyc();
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'(exp_lat));
    chk({tag, "_out"}, bus.out, exp_out);
    chk({tag, "_issues"}, 32'(iss_n - n0), 32'(exp_iss));
    if (exp_iss > 0) begin
      chk({tag, "_op0"}, 32'(iss_op[n0[7:0]]), (exp_iss == 1 && op != 2'b00) ? 32'(OP_MULH) : 32'(OP_MUL));
      chk({tag, "_ma"}, iss_a[n0[7:0]], exp_ma);
      chk({tag, "_mb"}, iss_b[n0[7:0]], exp_mb);
    end
    if (exp_iss == 2) begin
      chk({tag, "_op1"}, 32'(iss_op[n0[7:0] + 8'd1]), 32'(OP_MULH));
    end
    cyc();
    chk({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic saw;
    reset = 1'b0;
    bus.in_a = 32'd0;
    bus.in_b = 32'd0;
    bus.in_op = 2'b00;
    bus.in_valid = 1'b0;
    bus.kill = 1'b0;
    cyc();
    cyc();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out", bus.out, 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mul_valid", 32'(bus.mul_valid), 32'd0);
    chk("rst_mul_a", bus.mul_a, 32'd0);
    chk("rst_mul_b", bus.mul_b, 32'd0);
    chk("rst_mul_op", 32'(bus.mul_op), 32'(OP_MUL));
    reset = 1'b1;
    cyc();

    run_req("mul", 32'h12345678, 32'h10, 2'b00, 32'h23456780, 3, 1, 32'h12345678, 32'h10);
    run_req("mulhu", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'hFFFFFFFE, 3, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_req("mulh_m2x3", 32'hFFFFFFFE, 32'h3, 2'b01, 32'hFFFFFFFF, 5, 2, 32'h2, 32'h3);
    run_req("mulh_lozero", 32'hFFFF0000, 32'h00010000, 2'b01, 32'hFFFFFFFF, 5, 2, 32'h00010000, 32'h00010000);
    run_req("mulh_min", 32'h80000000, 32'h80000000, 2'b01, 32'h40000000, 3, 1, 32'h80000000, 32'h80000000);
    run_req("mulhsu", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFF, 5, 2, 32'h1, 32'hFFFFFFFF);
`ifdef FWRISC_MUL_SEQ_ZERO_BYPASS_EN
    run_req("mul_zero", 32'h0, 32'h5, 2'b00, 32'h0, 1, 0, 32'h0, 32'h5);
`else
    run_req("mul_zero", 32'h0, 32'h5, 2'b00, 32'h0, 3, 1, 32'h0, 32'h5);
`endif

    // Kill during WAIT_HI with a 2-cycle multiplier; its strobe lands in IDLE
    lat = 2;
    bus.in_a = 32'hFFFFFFFE;
    bus.in_b = 32'h3;
    bus.in_op = 2'b01;
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      saw = saw | bus.out_valid;
      cyc();
    end
    chk("kill_in_wait_hi_op", 32'(bus.mul_op), 32'(OP_MULH));
    chk("kill_in_wait_hi_mv", 32'(bus.mul_valid), 32'd0);
    bus.kill = 1'b1;
    saw = saw | bus.out_valid;
    cyc();
    bus.kill = 1'b0;
    saw = saw | bus.out_valid;
    chk("kill_no_out_valid", 32'(saw), 32'd0);
    chk("kill_idle_ready", 32'(bus.in_ready), 32'd1);
    lat = 1;
    run_req("kill_next", 32'h2, 32'h3, 2'b00, 32'h6, 3, 1, 32'h2, 32'h3);

    // Kill during DONE suppresses the completion pulse
    bus.in_a = 32'h7;
    bus.in_b = 32'h6;
    bus.in_op = 2'b00;
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    cyc();
    chk("done_state_out", bus.out, 32'd42);
    bus.kill = 1'b1;
    #1;
    chk("kill_done_out_valid", 32'(bus.out_valid), 32'd0);
    cyc();
    bus.kill = 1'b0;
    chk("kill_done_ready", 32'(bus.in_ready), 32'd1);

    // Kill together with in_valid in IDLE: request not accepted
    bus.in_a = 32'h5;
    bus.in_b = 32'h5;
    bus.in_valid = 1'b1;
    bus.kill = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    bus.kill = 1'b0;
    chk("kill_accept_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    chk("kill_accept_mul_valid", 32'(bus.mul_valid), 32'd0);

    // Asynchronous reset mid-operation
    bus.in_a = 32'h3;
    bus.in_b = 32'h4;
    bus.in_op = 2'b00;
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    chk("pre_rst_mul_valid", 32'(bus.mul_valid), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_mul_valid", 32'(bus.mul_valid), 32'd0);
    chk("midrst_mul_a", bus.mul_a, 32'd0);
    chk("midrst_out", bus.out, 32'd0);
    chk("midrst_mul_op", 32'(bus.mul_op), 32'(OP_MUL));
    cyc();
    reset = 1'b1;
    cyc();
    run_req("post_rst", 32'hFFFFFFFF, 32'h2, 2'b01, 32'hFFFFFFFF, 5, 2, 32'h1, 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
